tdm_demux: RTL and testbench

- Serial time-division demultiplexer: the receive end of the channel-select mux path.
- Takes one serial bit stream carrying NUM_CH interleaved words per frame, MSB first.
- Steers each word into its own parallel channel register and flags each channel update.
- Sits after the serial link and feeds per-channel consumers.

---
 rtl/tdm_pkg.sv | 22 ++
 rtl/tdm_shift_rx.sv | 55 +++++
 rtl/tdm_demux.sv | 176 +++++++++++++++++
 tb/tb_tdm_demux.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and width helpers for the serial TDM demultiplexer.
// Widths below are for the default configuration; modules derive their own from the same helpers.
package tdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_PAR  = 2'd2
  } tdm_state_e;

  localparam int unsigned NUM_CH_DEF = 2;
  localparam int unsigned WORD_W_DEF = 8;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BIT_CNT_W = cnt_w(WORD_W_DEF);
  localparam int unsigned CH_CNT_W  = cnt_w(NUM_CH_DEF);

endpackage

// File: rtl/tdm_shift_rx.sv
// MSB-first serial-to-parallel word assembler with bit counter.
// word_o presents the word including the bit being sampled, so the caller can store it on that edge.
module tdm_shift_rx
  import tdm_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_i,
  input  logic              en_i,
  input  logic              restart_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  localparam int unsigned BitCntW = cnt_w(WORD_W);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(WORD_W - 1);

  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [BitCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    word_done_o = 1'b0;
    word_o      = {shreg_q[WORD_W-2:0], bit_i};
    if (en_i) begin
      if (restart_i) begin
        // Restart bit is the MSB of a fresh word; stale partial bits are dropped.
        shreg_d = {{(WORD_W-1){1'b0}}, bit_i};
        cnt_d   = BitCntW'(1);
      end else begin
        shreg_d = word_o;
        if (cnt_q == LastBit) begin
          cnt_d       = '0;
          word_done_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: steers NUM_CH interleaved MSB-first words into channel registers.
// Define TDM_PARITY_EN to expect a trailing even-parity bit per frame and report par_err.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned WORD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din,
  input  logic                     din_en,
  input  logic                     fsync,
  output logic [NUM_CH*WORD_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_strobe,
  output logic                     frame_done,
  output logic                     sync_err,
  output logic                     par_err
);

  localparam int unsigned ChCntW = cnt_w(NUM_CH);
  localparam logic [ChCntW-1:0] LastCh = ChCntW'(NUM_CH - 1);

  tdm_state_e                state_q, state_d;
  logic [ChCntW-1:0]         ch_cnt_q, ch_cnt_d;
  logic [NUM_CH*WORD_W-1:0]  ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]         strobe_q, strobe_d;
  logic                      frame_done_q, frame_done_d;
  logic                      sync_err_q, sync_err_d;

  logic                      sr_en;
  logic                      sr_restart;
  logic [WORD_W-1:0]         word;
  logic                      word_done;

  // Any qualified fsync restarts the word; otherwise only data bits in RECV shift in.
  assign sr_restart = fsync;
  assign sr_en      = din_en & (fsync | (state_q == ST_RECV));

  tdm_shift_rx #(
    .WORD_W (WORD_W)
  ) u_shift_rx (
    .clk         (clk),
    .rst         (rst),
    .bit_i       (din),
    .en_i        (sr_en),
    .restart_i   (sr_restart),
    .word_o      (word),
    .word_done_o (word_done)
  );

`ifdef TDM_PARITY_EN
  logic parity_q, parity_d;
  logic par_err_q, par_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    ch_data_d    = ch_data_q;
    strobe_d     = '0;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err_q;
`ifdef TDM_PARITY_EN
    parity_d     = parity_q;
    par_err_d    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (din_en && fsync) begin
          ch_cnt_d = '0;
          state_d  = ST_RECV;
`ifdef TDM_PARITY_EN
          parity_d = din;
`endif
        end
      end

      ST_RECV: begin
        if (din_en) begin
          if (fsync) begin
            sync_err_d = 1'b1;
            ch_cnt_d   = '0;
`ifdef TDM_PARITY_EN
            parity_d   = din;
`endif
          end else begin
`ifdef TDM_PARITY_EN
            parity_d = parity_q ^ din;
`endif
            if (word_done) begin
              for (int k = 0; k < NUM_CH; k++) begin
                if (ch_cnt_q == ChCntW'(k)) begin
                  ch_data_d[k*WORD_W +: WORD_W] = word;
                  strobe_d[k]                   = 1'b1;
                end
              end
              if (ch_cnt_q == LastCh) begin
                ch_cnt_d = '0;
`ifdef TDM_PARITY_EN
                state_d  = ST_PAR;
`else
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
`endif
              end else begin
                ch_cnt_d = ch_cnt_q + 1'b1;
              end
            end
          end
        end
      end

`ifdef TDM_PARITY_EN
      ST_PAR: begin
        if (din_en) begin
          if (fsync) begin
            sync_err_d = 1'b1;
            ch_cnt_d   = '0;
            parity_d   = din;
            state_d    = ST_RECV;
          end else begin
            frame_done_d = 1'b1;
            // Even parity: XOR over data plus parity bit must be zero.
            par_err_d    = parity_q ^ din;
            state_d      = ST_IDLE;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_cnt_q     <= '0;
      ch_data_q    <= '0;
      strobe_q     <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      ch_data_q    <= ch_data_d;
      strobe_q     <= strobe_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

`ifdef TDM_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q  <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      parity_q  <= parity_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign ch_data    = ch_data_q;
  assign ch_strobe  = strobe_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: frame-level reference model pushes expected output events,
// an independent monitor pops and compares them whenever the DUT pulses a strobe.
module tb_tdm_demux;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned FW     = NUM_CH * WORD_W;
`ifdef TDM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, din, din_en, fsync;
  logic [FW-1:0] ch_data;
  logic [NUM_CH-1:0] ch_strobe;
  logic          frame_done, sync_err, par_err;

  always #5 clk = ~clk;

  tdm_demux #(
    .NUM_CH (NUM_CH),
    .WORD_W (WORD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_en     (din_en),
    .fsync      (fsync),
    .ch_data    (ch_data),
    .ch_strobe  (ch_strobe),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  typedef struct {
    logic [NUM_CH-1:0] mask;
    logic [FW-1:0]     data;
    logic              fd;
    logic              pe;
    logic              se;
    int unsigned       cyc;
  } ev_t;

  ev_t           q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  int unsigned   cyc    = 0;
  logic [FW-1:0] model_data;
  logic          sync_exp;
  logic          mid_frame;
  int            gap_mode;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int ch, input logic fd, input logic pe);
    ev_t e;
    e.mask = '0;
    if (ch >= 0) e.mask[ch] = 1'b1;
    e.data = model_data;
    e.fd   = fd;
    e.pe   = pe;
    e.se   = sync_exp;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endfunction

  // Monitor: compare every DUT output event against the next expected one.
  initial begin : monitor
    ev_t           e;
    logic          rst_s;
    logic [FW-1:0] prev;
    prev = '0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      if (ch_strobe != '0 || frame_done || par_err) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: strobe=%b frame_done=%b par_err=%b (t=%0t)",
                   ch_strobe, frame_done, par_err, $time);
        end else begin
          e = q.pop_front();
          check("ch_strobe", 64'(ch_strobe), 64'(e.mask));
          check("ch_data", 64'(ch_data), 64'(e.data));
          check("frame_done", 64'(frame_done), 64'(e.fd));
          check("par_err", 64'(par_err), 64'(e.pe));
          check("sync_err", 64'(sync_err), 64'(e.se));
          check("latency", 64'(cyc), 64'(e.cyc));
        end
      end else if (!rst_s) begin
        check("ch_data_hold", 64'(ch_data), 64'(prev));
      end
      prev = ch_data;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_bit(input logic b, input logic fs);
    int gap;
    gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
    repeat (gap) begin
      @(negedge clk);
      din_en = 1'b0;
      din    = 1'($urandom);
      fsync  = 1'($urandom);
    end
    @(negedge clk);
    din_en = 1'b1;
    din    = b;
    fsync  = fs;
  endtask

  task automatic go_idle();
    @(negedge clk);
    din_en = 1'b0;
    fsync  = 1'b0;
  endtask

  // Send the first nbits of frame f (ch0 in the low word); a full frame gets its parity bit.
  task automatic send_frame(input logic [FW-1:0] f, input int nbits, input logic bad_par);
    int ch;
    int bp;
    for (int i = 0; i < nbits; i++) begin
      ch = i / WORD_W;
      bp = WORD_W - 1 - (i % WORD_W);
      if (i == 0 && mid_frame) sync_exp = 1'b1;
      drive_bit(f[ch*WORD_W + bp], (i == 0));
      if ((i % WORD_W) == WORD_W - 1) begin
        model_data[ch*WORD_W +: WORD_W] = f[ch*WORD_W +: WORD_W];
        push(ch, !PAR_EN && (ch == NUM_CH - 1), 1'b0);
      end
    end
    if (nbits == FW && PAR_EN) begin
      drive_bit((^f) ^ bad_par, 1'b0);
      push(-1, 1'b1, bad_par);
    end
    mid_frame = (nbits < FW);
  endtask

  task automatic garbage(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'($urandom), 1'b0);
  endtask

  task automatic drain();
    go_idle();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'd0);
    check("quiet_ch_data", 64'(ch_data), 64'(model_data));
    check("quiet_sync_err", 64'(sync_err), 64'(sync_exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    din_en = 1'b0;
    fsync  = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    model_data = '0;
    sync_exp   = 1'b0;
    mid_frame  = 1'b0;
    check("rst_ch_data", 64'(ch_data), 64'd0);
    check("rst_ch_strobe", 64'(ch_strobe), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_par_err", 64'(par_err), 64'd0);
  endtask

  initial begin : stim
    logic [FW-1:0] f;
    int            nbits;
    rst        = 1'b1;
    din        = 1'b0;
    din_en     = 1'b0;
    fsync      = 1'b0;
    gap_mode   = 0;
    model_data = '0;
    sync_exp   = 1'b0;
    mid_frame  = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Contiguous frame, then the same frame with a gap before every bit.
    send_frame(16'h3CA5, FW, 1'b0);
    drain();
    gap_mode = 1;
    send_frame(16'h3CA5, FW, 1'b0);
    drain();

    // fsync at bit 5 of ch1, then a full new frame.
    gap_mode = 0;
    send_frame(16'hC3A5, 13, 1'b0);
    send_frame(16'h2211, FW, 1'b0);
    drain();
    check("t3_ch_data", 64'(ch_data), 64'h2211);

    // Reset mid-frame, then bits without fsync must be ignored.
    send_frame(16'h5A5A, 12, 1'b0);
    drain();
    do_reset();
    garbage(8);
    drain();
    check("t4_ch_data", 64'(ch_data), 64'h0);

    // Back-to-back frames.
    send_frame(16'h0201, FW, 1'b0);
    send_frame(16'h80FF, FW, 1'b0);
    drain();
    check("t5_ch_data", 64'(ch_data), 64'h80FF);

`ifdef TDM_PARITY_EN
    send_frame(16'h3CA5, FW, 1'b0);
    send_frame(16'h3CA5, FW, 1'b1);
    drain();
`endif

    // Randomized frames, aborts, idle noise, gaps and occasional resets.
    for (int it = 0; it < 80; it++) begin
      gap_mode = int'($urandom_range(0, 2));
      f        = FW'($urandom);
      nbits    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FW - 1)) : int'(FW);
      send_frame(f, nbits, PAR_EN ? 1'($urandom) : 1'b0);
      if (!mid_frame && $urandom_range(0, 3) == 0) garbage(int'($urandom_range(1, 5)));
      if ($urandom_range(0, 15) == 0) begin
        drain();
        do_reset();
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
